// File: rtl/rsa_host_sequencer_pkg.sv
// rtl/rsa_host_sequencer_pkg.sv - shared types and constants for the RSA host sequencer
package rsa_host_sequencer_pkg;

    typedef enum logic [2:0] {
        CMD_LOAD_N = 3'd0,
        CMD_LOAD_E = 3'd1,
        CMD_LOAD_X = 3'd2,
        CMD_RUN    = 3'd3,
        CMD_READ_U = 3'd4
    } host_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ
    } seq_state_e;

    // control_reg_type bit positions
    localparam int CTRL_LOAD_N = 0;
    localparam int CTRL_LOAD_E = 1;
    localparam int CTRL_LOAD_X = 2;
    localparam int CTRL_START  = 3;
    localparam int CTRL_READ_U = 4;
    localparam int CTRL_READY  = 5;
    localparam int CTRL_NU_LO  = 6;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rsa_rd_skid.sv
// rtl/rsa_rd_skid.sv - two-entry valid/ready buffer for result words read from the core
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_push               capture i_push_data/i_push_last this cycle
//   i_push_data/last     result word from the core and its last-word flag
//   o_rd_valid/data/last head entry presented to the host
//   i_rd_ready           host accepts the head entry
//   o_count              current occupancy (0..2)
module rsa_rd_skid #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_push_data,
    input  logic              i_push_last,
    output logic              o_rd_valid,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_rd_last,
    input  logic              i_rd_ready,
    output logic [1:0]        o_count
);

    logic [WORD_W-1:0] r_data0;
    logic              r_last0;
    logic [WORD_W-1:0] r_data1;
    logic              r_last1;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop      = (r_count != 2'd0) && i_rd_ready;
    assign o_rd_valid = (r_count != 2'd0);
    assign o_rd_data  = r_data0;
    assign o_rd_last  = r_last0;
    assign o_count    = r_count;

    // Entry 0 is always the head; the sequencer never pushes into a full buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_last0 <= 1'b0;
            r_data1 <= '0;
            r_last1 <= 1'b0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                    end else begin
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rsa_host_sequencer.sv
// rtl/rsa_host_sequencer.sv - host-side sequencer driving the RSA core control interface
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/nu   host command channel (accepted only in IDLE)
//   wr_valid/wr_ready/wr_data       operand word stream, LS word first
//   rd_valid/rd_ready/rd_data/last  result word stream, LS word first
//   ctrl_o                          control_reg_type: load_n/e/x, start, read_u, ready(0), nu_7_6
//   word_idx/word_data              word index and operand word for the core
//   core_ready/core_u_data          core status and result word (1 cycle after read_u)
//   busy                            not IDLE
//   run_cycles                      cycles from start to core ready of the last RUN
module rsa_host_sequencer
    import rsa_host_sequencer_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 32,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_nu,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_last,
    output logic [7:0]        ctrl_o,
    output logic [IDX_W-1:0]  word_idx,
    output logic [WORD_W-1:0] word_data,
    input  logic              core_ready,
    input  logic [WORD_W-1:0] core_u_data,
    output logic              busy,
    output logic [31:0]       run_cycles
);

    seq_state_e        r_state;
    seq_state_e        w_state_next;
    logic [2:0]        r_op;
    logic [1:0]        r_nu;
    logic [IDX_W-1:0]  r_count;
    logic              r_issue_done;
    logic              r_load_n;
    logic              r_load_e;
    logic              r_load_x;
    logic              r_start;
    logic              r_read_u;
    logic              r_read_u_d;
    logic              r_read_last;
    logic              r_read_last_d;
    logic [IDX_W-1:0]  r_word_idx;
    logic [WORD_W-1:0] r_word_data;
    logic [31:0]       r_run_cnt;
    logic [31:0]       r_run_cycles;

    logic              w_cmd_hs;
    logic              w_wr_hs;
    logic              w_last_idx;
    logic              w_rd_issue;
    logic              w_load_n;
    logic              w_load_e;
    logic              w_load_x;
    logic              w_start;
    logic [1:0]        w_skid_count;
    logic [2:0]        w_occupancy;
    logic [31:0]       w_run_inc;

    assign cmd_ready  = (r_state == S_IDLE);
    assign wr_ready   = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign w_cmd_hs   = cmd_valid && (r_state == S_IDLE);
    assign w_wr_hs    = wr_valid && (r_state == S_LOAD);
    assign w_last_idx = (r_count == IDX_W'(NUM_WORDS - 1));
    assign w_run_inc  = sat_inc32(r_run_cnt);

    // A read may be issued only if its word is guaranteed a skid slot even
    // when the host stalls: buffered words plus both read pipeline stages.
    assign w_occupancy = {1'b0, w_skid_count} + {2'b00, r_read_u} + {2'b00, r_read_u_d};

    always_comb begin
        w_state_next = r_state;
        w_load_n     = 1'b0;
        w_load_e     = 1'b0;
        w_load_x     = 1'b0;
        w_start      = 1'b0;
        w_rd_issue   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    case (cmd_op)
                        CMD_LOAD_N, CMD_LOAD_E, CMD_LOAD_X: w_state_next = S_LOAD;
                        CMD_RUN:                            w_state_next = S_START;
                        CMD_READ_U:                         w_state_next = S_READ;
                        default:                            w_state_next = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                w_load_n = w_wr_hs && (r_op == CMD_LOAD_N);
                w_load_e = w_wr_hs && (r_op == CMD_LOAD_E);
                w_load_x = w_wr_hs && (r_op == CMD_LOAD_X);
                if (w_wr_hs && w_last_idx) begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                w_start      = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (core_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            S_READ: begin
                w_rd_issue = !r_issue_done && (w_occupancy < 3'd2);
                if (r_issue_done && !r_read_u && !r_read_u_d && (w_skid_count == 2'd0)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op          <= 3'd0;
            r_nu          <= 2'd0;
            r_count       <= '0;
            r_issue_done  <= 1'b0;
            r_load_n      <= 1'b0;
            r_load_e      <= 1'b0;
            r_load_x      <= 1'b0;
            r_start       <= 1'b0;
            r_read_u      <= 1'b0;
            r_read_u_d    <= 1'b0;
            r_read_last   <= 1'b0;
            r_read_last_d <= 1'b0;
            r_word_idx    <= '0;
            r_word_data   <= '0;
            r_run_cnt     <= 32'd0;
            r_run_cycles  <= 32'd0;
        end else begin
            r_load_n      <= w_load_n;
            r_load_e      <= w_load_e;
            r_load_x      <= w_load_x;
            r_start       <= w_start;
            r_read_u      <= w_rd_issue;
            r_read_u_d    <= r_read_u;
            r_read_last   <= w_rd_issue && w_last_idx;
            r_read_last_d <= r_read_last;

            if (w_cmd_hs) begin
                r_op         <= cmd_op;
                r_count      <= '0;
                r_issue_done <= 1'b0;
                if (cmd_op == CMD_RUN) begin
                    r_nu <= cmd_nu;
                end
            end else if (w_wr_hs || w_rd_issue) begin
                r_count <= w_last_idx ? '0 : r_count + IDX_W'(1);
                if (w_rd_issue && w_last_idx) begin
                    r_issue_done <= 1'b1;
                end
            end

            if (w_wr_hs) begin
                r_word_idx  <= r_count;
                r_word_data <= wr_data;
            end else if (w_rd_issue) begin
                r_word_idx <= r_count;
            end

            if (r_state == S_START) begin
                r_run_cnt <= 32'd0;
            end else if (r_state == S_WAIT) begin
                r_run_cnt <= w_run_inc;
                if (core_ready) begin
                    r_run_cycles <= w_run_inc;
                end
            end
        end
    end

    always_comb begin
        ctrl_o                     = 8'd0;
        ctrl_o[CTRL_LOAD_N]        = r_load_n;
        ctrl_o[CTRL_LOAD_E]        = r_load_e;
        ctrl_o[CTRL_LOAD_X]        = r_load_x;
        ctrl_o[CTRL_START]         = r_start;
        ctrl_o[CTRL_READ_U]        = r_read_u;
        ctrl_o[CTRL_READY]         = 1'b0;
        ctrl_o[CTRL_NU_LO +: 2]    = r_nu;
    end

    assign word_idx   = r_word_idx;
    assign word_data  = r_word_data;
    assign run_cycles = r_run_cycles;

    // core_u_data is valid the cycle after read_u, which is when r_read_u_d is high.
    rsa_rd_skid #(
        .WORD_W (WORD_W)
    ) u_rd_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_read_u_d),
        .i_push_data (core_u_data),
        .i_push_last (r_read_last_d),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_rd_last   (rd_last),
        .i_rd_ready  (rd_ready),
        .o_count     (w_skid_count)
    );

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// tb/tb_rsa_host_sequencer.sv - directed self-checking bench for rsa_host_sequencer
module tb_rsa_host_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_nu;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [7:0]  ctrl_o;
    logic [4:0]  word_idx;
    logic [31:0] word_data;
    logic        core_ready;
    logic [31:0] core_u_data;
    logic        busy;
    logic [31:0] run_cycles;

    int n_checks = 0;
    int n_errors = 0;

    int mon_pulses [5];
    int mon_load_total = 0;
    int snap [5];

    rsa_host_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_nu      (cmd_nu),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .ctrl_o      (ctrl_o),
        .word_idx    (word_idx),
        .word_data   (word_data),
        .core_ready  (core_ready),
        .core_u_data (core_u_data),
        .busy        (busy),
        .run_cycles  (run_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_base(input int b);
        case (b)
            0:       return 32'h0000_0000;
            1:       return 32'hE000_0000;
            default: return 32'hA500_0000;
        endcase
    endfunction

    // Core model: u word for the requested index one cycle after read_u.
    always @(posedge clk) begin
        core_u_data <= ctrl_o[4] ? (32'(word_idx) * 32'd3) : 32'hDEAD_BEEF;
    end

    // Pulse monitor: counts control pulses and checks each load word.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int b = 0; b < 5; b++) begin
                if (ctrl_o[b]) mon_pulses[b]++;
            end
            for (int b = 0; b < 3; b++) begin
                if (ctrl_o[b]) begin
                    expect_eq("load_idx", 64'(word_idx), 64'(mon_load_total % 32));
                    expect_eq("load_data", 64'(word_data), 64'(load_base(b) | 32'(mon_load_total % 32)));
                end
            end
            if (|ctrl_o[2:0]) mon_load_total++;
        end
    end

    task automatic take_snap();
        for (int b = 0; b < 5; b++) snap[b] = mon_pulses[b];
    endtask

    task automatic expect_pulses(input string tag, input int b, input int exp);
        expect_eq(tag, 64'(mon_pulses[b] - snap[b]), 64'(exp));
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] nu);
        @(negedge clk);
        expect_eq("cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_nu    = nu;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] base, input bit gaps);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < 32 && cyc < 500) begin
            if (cyc != 0) @(negedge clk);
            wr_valid = !gaps || (cyc % 3 == 0);
            wr_data  = base | 32'(k);
            if (wr_valid && wr_ready) k++;
            cyc++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        expect_eq("load_words_done", 64'(k), 64'd32);
        @(negedge clk);
        expect_eq("load_busy_after", 64'(busy), 64'd0);
        expect_eq("load_cmd_ready_after", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_run(input logic [1:0] nu, input int delay, input bit pre_ready, input int exp_cycles);
        bit seen;
        core_ready = pre_ready;
        take_snap();
        send_cmd(3'd3, nu);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (ctrl_o[3]) seen = 1'b1;
            else @(negedge clk);
        end
        expect_eq("start_seen", 64'(seen), 64'd1);
        expect_eq("start_nu", 64'(ctrl_o[7:6]), 64'(nu));
        if (!pre_ready) begin
            repeat (delay - 1) @(negedge clk);
            expect_eq("busy_in_wait", 64'(busy), 64'd1);
            core_ready = 1'b1;
        end
        @(negedge clk);
        core_ready = 1'b0;
        expect_eq("busy_after_run", 64'(busy), 64'd0);
        expect_eq("run_cycles", 64'(run_cycles), 64'(exp_cycles));
        @(negedge clk);
        expect_pulses("start_pulses", 3, 1);
        expect_eq("nu_held", 64'(ctrl_o[7:6]), 64'(nu));
    endtask

    task automatic read_words(input int n_words, output int got_n);
        int n;
        int cyc;
        n   = 0;
        cyc = 0;
        while (n < n_words && cyc < 2000) begin
            @(negedge clk);
            rd_ready = cyc[0];
            if (rd_valid && rd_ready) begin
                expect_eq("rd_data", 64'(rd_data), 64'(32'(n) * 32'd3));
                expect_eq("rd_last", 64'(rd_last), 64'(n == 31));
                n++;
            end
            cyc++;
        end
        @(negedge clk);
        rd_ready = 1'b0;
        got_n = n;
    endtask

    initial begin
        int got_n;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_nu     = 2'd0;
        wr_valid   = 1'b0;
        wr_data    = 32'd0;
        rd_ready   = 1'b0;
        core_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        expect_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        expect_eq("rst_busy", 64'(busy), 64'd0);
        expect_eq("rst_ctrl", 64'(ctrl_o), 64'd0);
        expect_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        expect_eq("rst_wr_ready", 64'(wr_ready), 64'd0);
        expect_eq("rst_run_cycles", 64'(run_cycles), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LOAD_N, continuous words 0..31
        take_snap();
        send_cmd(3'd0, 2'd0);
        expect_eq("load_wr_ready", 64'(wr_ready), 64'd1);
        load_words(32'h0000_0000, 1'b0);
        expect_pulses("load_n_pulses", 0, 32);
        expect_pulses("load_e_none", 1, 0);
        expect_pulses("load_x_none", 2, 0);

        // LOAD_X with valid one cycle in three
        take_snap();
        send_cmd(3'd2, 2'd0);
        load_words(32'hA500_0000, 1'b1);
        expect_pulses("load_x_pulses", 2, 32);
        expect_pulses("load_n_none", 0, 0);

        // RUN, core ready in the 100th wait cycle
        do_run(2'b10, 100, 1'b0, 100);

        // READ_U with 50% backpressure
        take_snap();
        send_cmd(3'd4, 2'd0);
        read_words(32, got_n);
        expect_eq("read_count", 64'(got_n), 64'd32);
        repeat (3) @(negedge clk);
        expect_eq("read_busy_after", 64'(busy), 64'd0);
        expect_eq("read_rd_valid_after", 64'(rd_valid), 64'd0);
        expect_pulses("read_u_pulses", 4, 32);

        // reset during WAIT
        core_ready = 1'b0;
        send_cmd(3'd3, 2'b01);
        repeat (5) @(negedge clk);
        expect_eq("wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        take_snap();
        @(negedge clk);
        expect_eq("rst_wait_busy", 64'(busy), 64'd0);
        expect_eq("rst_wait_ctrl", 64'(ctrl_o), 64'd0);
        expect_eq("rst_wait_rd_valid", 64'(rd_valid), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_pulses("rst_wait_no_start", 3, 0);

        // fresh RUN with core_ready already high
        do_run(2'b01, 1, 1'b1, 1);

        // reset mid-READ
        send_cmd(3'd4, 2'd0);
        read_words(10, got_n);
        expect_eq("partial_read", 64'(got_n), 64'd10);
        rst_n = 1'b0;
        @(negedge clk);
        expect_eq("rst_read_busy", 64'(busy), 64'd0);
        expect_eq("rst_read_ctrl", 64'(ctrl_o), 64'd0);
        expect_eq("rst_read_rd_valid", 64'(rd_valid), 64'd0);
        rst_n = 1'b1;
        take_snap();
        repeat (6) @(negedge clk);
        expect_pulses("rst_read_no_read_u", 4, 0);
        expect_eq("rst_read_rd_valid_later", 64'(rd_valid), 64'd0);
        do_run(2'b11, 5, 1'b0, 5);

        // undefined op and stray write data
        take_snap();
        send_cmd(3'd7, 2'd0);
        expect_eq("op7_busy", 64'(busy), 64'd0);
        wr_valid = 1'b1;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 5; b++) expect_pulses("op7_no_pulse", b, 0);

        // command while busy is ignored
        take_snap();
        send_cmd(3'd1, 2'd0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_nu    = 2'b00;
        expect_eq("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        load_words(32'hE000_0000, 1'b0);
        expect_pulses("load_e_pulses", 1, 32);
        expect_pulses("busy_cmd_no_start", 3, 0);
        expect_eq("busy_cmd_nu_kept", 64'(ctrl_o[7:6]), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
